// File: rtl/input_scaler.sv
// input_scaler: integrates the 8-sample pulse window of a 16-sample ADC word,
// subtracts a programmable offset, arithmetic-right-shifts by a programmable
// amount and saturates to an unsigned 8-bit value. Offset and shift are
// loaded through a two-phase MSB/LSB GPIO write protocol.
module input_scaler #(
    parameter int unsigned mem_base_addr = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] adc_word_in,
    input  logic         adc_valid_in,
    input  logic [31:0]  gpio_in,
    output logic [7:0]   value_out,
    output logic         value_valid_out
);

    // GPIO field layout: [7:0] data, [23:8] address, [31] write strobe.
    localparam int unsigned GpioWClkBit = 31;
    localparam logic [15:0] OffsetAddr  = 16'(mem_base_addr);
    localparam logic [15:0] ShiftAddr   = 16'(mem_base_addr + 1);

    typedef enum logic [1:0] {StIdle, StWait1, StWait2, StWaitEnd} wr_state_e;

    logic [7:0]  gpio_data;
    logic [15:0] gpio_addr;
    logic        gpio_w_clk;
    logic        hit_offset, hit_shift, hit;

    assign gpio_data  = gpio_in[7:0];
    assign gpio_addr  = gpio_in[23:8];
    assign gpio_w_clk = gpio_in[GpioWClkBit];
    assign hit_offset = gpio_w_clk && (gpio_addr == OffsetAddr);
    assign hit_shift  = gpio_w_clk && (gpio_addr == ShiftAddr);
    assign hit        = hit_offset || hit_shift;

    // Edge samples, unused GPIO bits and the upper shift bits carry no function.
    logic unused_inputs;
    assign unused_inputs = ^{gpio_in[30:24], adc_word_in[63:0], adc_word_in[255:192]};

    wr_state_e   state_q, state_d;
    logic [7:0]  msb_q, msb_d;
    logic [15:0] offset_q, offset_d;
    logic [15:0] shift_q, shift_d;

    logic unused_shift;
    assign unused_shift = ^shift_q[15:4];

    // Config write FSM: next state and register updates.
    always_comb begin
        state_d  = state_q;
        msb_d    = msb_q;
        offset_d = offset_q;
        shift_d  = shift_q;
        case (state_q)
            StIdle: begin
                if (hit) begin
                    msb_d   = gpio_data;
                    state_d = StWait1;
                end
            end
            StWait1: begin
                if (!gpio_w_clk) state_d = StWait2;
            end
            StWait2: begin
                // The address of the LSB phase selects the target register.
                if (hit) begin
                    if (hit_offset) offset_d = {msb_q, gpio_data};
                    else            shift_d  = {msb_q, gpio_data};
                    state_d = StWaitEnd;
                end
            end
            StWaitEnd: begin
                if (!gpio_w_clk) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Config write FSM state and register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            msb_q    <= '0;
            offset_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            msb_q    <= msb_d;
            offset_q <= offset_d;
            shift_q  <= shift_d;
        end
    end

    // Datapath signals.
    logic signed [15:0] smp [8];
    logic signed [16:0] pair_d [4];
    logic signed [16:0] pair_q [4];
    logic               s1_valid_q;
    logic signed [18:0] total_d, total_q;
    logic               s2_valid_q;
    logic signed [19:0] diff_d, diff_q;
    logic               s3_valid_q;
    logic signed [19:0] shifted;
    logic [7:0]         sat;

    // S1/S2/S3 combinational arithmetic: pair sums, total, offset removal.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            smp[j] = adc_word_in[16*(j+4) +: 16];
        end
        for (int i = 0; i < 4; i++) begin
            pair_d[i] = {smp[2*i][15], smp[2*i]} + {smp[2*i+1][15], smp[2*i+1]};
        end
        total_d = {{2{pair_q[0][16]}}, pair_q[0]} + {{2{pair_q[1][16]}}, pair_q[1]}
                + {{2{pair_q[2][16]}}, pair_q[2]} + {{2{pair_q[3][16]}}, pair_q[3]};
        diff_d  = {total_q[18], total_q} - {{4{offset_q[15]}}, offset_q};
    end

    // S4: arithmetic shift then clamp into 0..255.
    always_comb begin
        shifted = diff_q >>> shift_q[3:0];
        if (shifted[19])          sat = 8'd0;
        else if (|shifted[18:8])  sat = 8'd255;
        else                      sat = shifted[7:0];
    end

    // Pipeline registers; valid travels alongside data, output holds on bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) pair_q[i] <= '0;
            s1_valid_q      <= 1'b0;
            total_q         <= '0;
            s2_valid_q      <= 1'b0;
            diff_q          <= '0;
            s3_valid_q      <= 1'b0;
            value_out       <= '0;
            value_valid_out <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) pair_q[i] <= pair_d[i];
            s1_valid_q      <= adc_valid_in;
            total_q         <= total_d;
            s2_valid_q      <= s1_valid_q;
            diff_q          <= diff_d;
            s3_valid_q      <= s2_valid_q;
            value_valid_out <= s3_valid_q;
            if (s3_valid_q) value_out <= sat;
        end
    end

endmodule

// File: tb/tb_input_scaler.sv
// Scoreboard bench for input_scaler: directed scenarios plus randomized words,
// expected values from an arithmetic reference model, checked by a monitor.
module tb_input_scaler;

    localparam int unsigned Base = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] adc_word_in;
    logic         adc_valid_in;
    logic [31:0]  gpio_in;
    logic [7:0]   value_out;
    logic         value_valid_out;

    input_scaler #(.mem_base_addr(Base)) dut (
        .clk             (clk),
        .rst             (rst),
        .adc_word_in     (adc_word_in),
        .adc_valid_in    (adc_valid_in),
        .gpio_in         (gpio_in),
        .value_out       (value_out),
        .value_valid_out (value_valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Model configuration as seen by software.
    logic signed [15:0] m_offset = '0;
    int                 m_shift = 0;

    // Reference: integrate samples 4..11, remove offset, divide by 2^shift, clamp.
    function automatic int model(input logic [255:0] w);
        int sum = 0;
        int d;
        logic signed [15:0] s;
        for (int k = 4; k < 12; k++) begin
            s = w[16*k +: 16];
            sum += int'(s);
        end
        d = sum - int'(m_offset);
        if (d < 0) return 0;
        d = d / (1 << m_shift);
        return (d > 255) ? 255 : d;
    endfunction

    function automatic logic [255:0] mk_word(input logic [15:0] edge_s, input logic [15:0] mid_s);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[16*k +: 16] = (k >= 4 && k < 12) ? mid_s : edge_s;
        return w;
    endfunction

    // Monitor: every strobe must match the head of the queue, on time.
    always @(negedge clk) begin
        exp_t e;
        if (rst && value_valid_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe value=%0d expected no output at cycle %0d",
                         value_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (value_out !== 8'(e.val) || cyc != e.cyc + 4) begin
                    bad++;
                    $display("FAIL strobe value=%0d at cycle %0d, required value=%0d at cycle %0d",
                             value_out, cyc, e.val, e.cyc + 4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [255:0] w, input logic v);
        exp_t e;
        tick();
        adc_word_in  = w;
        adc_valid_in = v;
        if (v) begin
            e.val = model(w);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            adc_valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (exp_q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    task automatic gpio_phase(input logic [15:0] addr, input logic [7:0] data, input int hold);
        tick();
        gpio_in = {1'b1, 7'b0, addr, data};
        repeat (hold) tick();
        gpio_in[31] = 1'b0;
        tick();
    endtask

    task automatic cfg_write(input logic [15:0] addr, input logic [7:0] msb,
                             input logic [7:0] lsb, input int hold);
        drain();
        gpio_phase(addr, msb, hold);
        gpio_phase(addr, lsb, 1);
        if (addr == 16'(Base))          m_offset = {msb, lsb};
        else if (addr == 16'(Base + 1)) m_shift = int'({msb, lsb}) % 16;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        logic [255:0] w;
        rst = 1'b0;
        adc_word_in = '0;
        adc_valid_in = 1'b0;
        gpio_in = '0;
        repeat (3) @(negedge clk);
        check8("reset_value", value_out, 8'd0);
        check8("reset_valid", {7'b0, value_valid_out}, 8'd0);
        rst = 1'b1;
        idle(2);
        check8("post_reset_valid", {7'b0, value_valid_out}, 8'd0);

        // Shift 5: 8000 >> 5 = 250.
        cfg_write(16'(Base + 1), 8'h00, 8'h05, 1);
        send(mk_word(16'd0, 16'd1000), 1'b1);
        drain();
        // Shift 4: saturate high and low.
        cfg_write(16'(Base + 1), 8'h00, 8'h04, 1);
        send(mk_word(16'd0, 16'd1000), 1'b1);
        send(mk_word(16'd0, 16'hFF9C), 1'b1);
        // Offset 4000: (8000-4000) >> 4 = 250.
        cfg_write(16'(Base), 8'h0F, 8'hA0, 1);
        send(mk_word(16'd0, 16'd1000), 1'b1);
        cfg_write(16'(Base), 8'h00, 8'h00, 1);
        send(mk_word(16'h7FFF, 16'd0), 1'b1);

        // Back-to-back run with a bubble in the middle, shift 3.
        cfg_write(16'(Base + 1), 8'h00, 8'h03, 1);
        for (int k = 0; k < 16; k++) begin
            if (k == 8) send('0, 1'b0);
            send(mk_word(16'd0, 16'(32 * k)), 1'b1);
        end

        // Stray out-of-range write between MSB and LSB phases.
        cfg_write(16'(Base + 1), 8'h00, 8'h02, 1);
        drain();
        gpio_phase(16'(Base), 8'h01, 1);
        gpio_phase(16'(Base + 5), 8'hAA, 1);
        gpio_phase(16'(Base), 8'h90, 1);
        m_offset = 16'h0190;
        send(mk_word(16'd0, 16'd100), 1'b1);
        // Long w_clk on the first phase counts once; upper shift bits ignored.
        cfg_write(16'(Base + 1), 8'h12, 8'h03, 10);
        send(mk_word(16'd0, 16'd100), 1'b1);
        send(mk_word(16'd0, 16'd200), 1'b1);

        // Randomized words with periodic random reconfiguration.
        for (int blk = 0; blk < 6; blk++) begin
            cfg_write(16'(Base), 8'($urandom_range(0, 3) == 0 ? $urandom : 0),
                      8'($urandom), $urandom_range(1, 3));
            cfg_write(16'(Base + 1), 8'($urandom), 8'($urandom_range(0, 8)),
                      $urandom_range(1, 3));
            for (int i = 0; i < 40; i++) begin
                for (int k = 0; k < 16; k++) begin
                    if ($urandom_range(0, 3) == 0) w[16*k +: 16] = 16'($urandom);
                    else w[16*k +: 16] = 16'($urandom_range(0, 1279)) - 16'd256;
                end
                send(w, 1'($urandom_range(0, 3) != 0));
            end
        end

        // Reset two cycles after a valid input: it must never emerge.
        drain();
        send(mk_word(16'd0, 16'd1000), 1'b1);
        idle(1);
        tick();
        rst = 1'b0;
        exp_q.delete();
        adc_valid_in = 1'b0;
        idle(2);
        rst = 1'b1;
        m_offset = '0;
        m_shift = 0;
        idle(8);
        @(negedge clk);
        check8("reset_flush_value", value_out, 8'd0);
        // Offset and shift back to zero: 8*10 = 80.
        send(mk_word(16'd0, 16'd10), 1'b1);
        send(mk_word(16'd0, 16'd3), 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_scaler.md
Name: input_scaler

Overview:
- Receive-side counterpart of the output scaler. Takes a 256-bit ADC word (16 × 16-bit signed samples) carrying the returned 2 ns pulse in the middle 8 samples.
- Integrates the pulse window, removes a programmable offset, applies a programmable right shift, and saturates to the 8-bit value domain the Ising core consumes.
- Offset and shift are programmed over the shared 32-bit GPIO bus using the same two-phase MSB/LSB write protocol as the output LUT.

Parameters:
mem_base_addr, 0, GPIO address of the offset register; the shift register sits at mem_base_addr+1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
adc_word_in  input  256  ADC word; sample k = bits [16k+15:16k], two's complement
adc_valid_in  input  1  adc_word_in valid this cycle
gpio_in  input  32  GPIO bus: address, data and w_clk fields per ising_config (gpio_addr_*, gpio_data_*, gpio_w_clk_bit); synchronous to clk
value_out  output  8  scaled unsigned value
value_valid_out  output  1  value_out valid this cycle (single-cycle strobe per input)

Behaviour:
- Reset (async, rst low):
  - value_out=0, value_valid_out=0, all pipeline valids=0.
  - offset_reg=0, shift_reg=0, msb_temp=0, write FSM=state_idle.
  - Reset mid-pipeline discards all in-flight samples; no valid is emitted after release for pre-reset inputs.
- Datapath, fully pipelined, 1 word/cycle, latency 4 cycles (adc_valid_in at cycle N -> value_valid_out at N+4):
  - S1: four 17-bit signed pair sums (s4+s5, s6+s7, s8+s9, s10+s11). Samples 0–3 and 12–15 are ignored.
  - S2: 19-bit signed total of the S1 sums.
  - S3: 20-bit signed diff = total − sign_extend(offset_reg). offset_reg is sampled in this stage.
  - S4: arithmetic right shift of diff by shift_reg[3:0], sampled in this stage; then saturate:
    - <0 -> 0
    - >255 -> 255
    - else low 8 bits.
  - value_out holds its last value while value_valid_out=0.
  - Valid bit propagates with data. Bubbles (adc_valid_in=0) propagate as bubbles. Data regs may update on bubbles, but value_out updates only on valid.
- Config write FSM (states: state_idle, state_wait_1, state_wait_2, state_wait_end). "Hit" = w_clk=1 and gpio_addr ∈ {mem_base_addr, mem_base_addr+1}.
  - state_idle: on hit, msb_temp<=gpio_data; -> state_wait_1.
  - state_wait_1: on w_clk=0 -> state_wait_2.
  - state_wait_2: on hit, write {msb_temp, gpio_data} to the register selected by the address (the second write's address decides); -> state_wait_end.
  - state_wait_end: on w_clk=0 -> state_idle.
  - Writes to out-of-range addresses are ignored in every state and do not advance the FSM.
  - w_clk is held high ≥1 clk per write. A level held high for many cycles counts once.
  - The shift register stores the full 16 bits; only [3:0] is used.
  - A config change while samples are in flight takes effect in whichever stage next samples it (S3/S4). This is deterministic and needs no stall.

Test Plan:
- Reset, shift=5 via writes (0x00 @base+1, then 0x05 @base+1); samples 4–11 = 1000, others 0, one valid -> value_valid_out exactly 4 cycles later, value_out=250.
- Same stimulus with shift=4 -> 8000>>4=500 -> value_out=255 (saturate high). Middle samples = −100 (0xFF9C) -> value_out=0 (saturate low).
- Offset=0x0FA0 written (0x0F then 0xA0 @base), shift=4, samples 4–11 = 1000 -> (8000−4000)>>4 = value_out=250. Edge samples 0–3 and 12–15 = 0x7FFF with middle 0, offset 0 -> value_out=0.
- Back-to-back valids for 16 cycles with middle sample values 0..15 step 32, shift=3 -> 16 consecutive strobes, value_out = 32·k·8>>3 saturated, in order. A bubble inserted -> a matching gap in value_valid_out.
- GPIO protocol:
  - Write @base+5 between the MSB and LSB phases -> ignored, FSM stays in state_wait_2; subsequent LSB @base completes offset.
  - w_clk held high 10 cycles on first phase -> captured once.
- Assert rst low 2 cycles after a valid input -> no value_valid_out ever appears for it; value_out=0, offset/shift back to 0.
